// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer signal bundle for sync_fifo_prog.
// Widths follow the FIFO parameters, so instantiate it with the same values as the FIFO.
interface sync_fifo_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 12
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;
  logic                  sticky_ovf;
  logic                  sticky_udf;

  modport master (
    output wr_en, rd_en, data_in, af_thresh, ae_thresh, err_clr,
    input  data_out, data_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, sticky_ovf, sticky_udf
  );

  modport slave (
    input  wr_en, rd_en, data_in, af_thresh, ae_thresh, err_clr,
    output data_out, data_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, sticky_ovf, sticky_udf
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, read-valid strobe and sticky error flags.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 12
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_prog_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  sticky_ovf_q;
  logic                  sticky_udf_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Pointers wrap explicitly because the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_ok = bus.wr_en && (count_q < CNT_W'(FIFO_DEPTH));
  assign rd_ok = bus.rd_en && (count_q != '0);

  always_comb begin
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_udf_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        data_out_q <= mem[rd_ptr];
      end
      count_q      <= count_next;
      data_valid_q <= rd_ok;
      wr_ack_q     <= wr_ok;
      overflow_q   <= bus.wr_en && !wr_ok;
      underflow_q  <= bus.rd_en && !rd_ok;
      // A new event in the same cycle as err_clr keeps the flag set.
      if (bus.wr_en && !wr_ok) begin
        sticky_ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        sticky_ovf_q <= 1'b0;
      end
      if (bus.rd_en && !rd_ok) begin
        sticky_udf_q <= 1'b1;
      end else if (bus.err_clr) begin
        sticky_udf_q <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign bus.empty       = (count_q == '0);
  assign bus.almostfull  = (bus.af_thresh != '0) && (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);
  assign bus.sticky_ovf  = sticky_ovf_q;
  assign bus.sticky_udf  = sticky_udf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog (depth 12, width 16).
module tb_sync_fifo_prog;
  localparam int W = 16;
  localparam int D = 12;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of requests, then returns 1ns after the edge with requests idle.
  task automatic applyStimulus(input logic w, input logic r, input logic [W-1:0] d, input logic clr);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.data_in   = '0;
    bus.err_clr   = 1'b0;
    bus.af_thresh = 4'd10;
    bus.ae_thresh = 4'd2;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_ae", 32'(bus.almostempty), 32'd1);
    checkOutput("rst_af", 32'(bus.almostfull), 32'd0);
    checkOutput("rst_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("rst_sticky", 32'({bus.sticky_ovf, bus.sticky_udf}), 32'd0);
    rst = 1'b0;

    $display("[TB] test 1: fill and drain");
    for (int i = 1; i <= D; i++) begin
      applyStimulus(1'b1, 1'b0, W'(i), 1'b0);
      checkOutput("fill_ack", 32'(bus.wr_ack), 32'd1);
    end
    checkOutput("fill_count", 32'(bus.count), 32'd12);
    checkOutput("fill_full", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h000D, 1'b0);
    checkOutput("ovf_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_sticky", 32'(bus.sticky_ovf), 32'd1);
    checkOutput("ovf_count", 32'(bus.count), 32'd12);
    for (int i = 1; i <= D; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      checkOutput("drain_data", 32'(bus.data_out), 32'(i));
      checkOutput("drain_valid", 32'(bus.data_valid), 32'd1);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    $display("[TB] test 2: wrap-around");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, W'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      checkOutput("pre_wrap_data", 32'(bus.data_out), 32'(16'h0100 + i));
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, W'(16'h00A0 + i), 1'b0);
    checkOutput("wrap_count5", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      checkOutput("wrap_data", 32'(bus.data_out), 32'(16'h00A0 + i));
    end
    checkOutput("wrap_count0", 32'(bus.count), 32'd0);

    $display("[TB] test 3: simultaneous access at boundaries");
    for (int i = 0; i < D; i++) applyStimulus(1'b1, 1'b0, W'(16'h0200 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0);
    checkOutput("full_rw_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("full_rw_valid", 32'(bus.data_valid), 32'd1);
    checkOutput("full_rw_data", 32'(bus.data_out), 32'h0200);
    checkOutput("full_rw_ack", 32'(bus.wr_ack), 32'd0);
    checkOutput("full_rw_count", 32'(bus.count), 32'd11);
    for (int i = 1; i < D; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      checkOutput("full_rw_drain", 32'(bus.data_out), 32'(16'h0200 + i));
    end
    applyStimulus(1'b1, 1'b1, 16'h0055, 1'b0);
    checkOutput("empty_rw_udf", 32'(bus.underflow), 32'd1);
    checkOutput("empty_rw_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("empty_rw_ack", 32'(bus.wr_ack), 32'd1);
    checkOutput("empty_rw_count", 32'(bus.count), 32'd1);
    checkOutput("empty_rw_hold", 32'(bus.data_out), 32'h020B);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    checkOutput("empty_rw_data", 32'(bus.data_out), 32'h0055);

    $display("[TB] test 4: thresholds");
    applyStimulus(1'b1, 1'b0, 16'h0301, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0302, 1'b0);
    checkOutput("ae_at2", 32'(bus.almostempty), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0303, 1'b0);
    checkOutput("ae_at3", 32'(bus.almostempty), 32'd0);
    for (int i = 4; i <= 9; i++) applyStimulus(1'b1, 1'b0, W'(16'h0300 + i), 1'b0);
    checkOutput("af_at9", 32'(bus.almostfull), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h030A, 1'b0);
    checkOutput("af_at10", 32'(bus.almostfull), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h030B, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h030C, 1'b0);
    checkOutput("af_at12", 32'(bus.almostfull), 32'd1);
    bus.af_thresh = 4'd0;
    #1;
    checkOutput("af_disabled", 32'(bus.almostfull), 32'd0);
    bus.af_thresh = 4'd13;
    bus.ae_thresh = 4'd12;
    #1;
    checkOutput("af_above_depth", 32'(bus.almostfull), 32'd0);
    checkOutput("ae_at_depth", 32'(bus.almostempty), 32'd1);
    bus.af_thresh = 4'd10;
    bus.ae_thresh = 4'd2;

    $display("[TB] test 5: asynchronous reset mid-stream");
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, W'(16'h0400 + i), 1'b0);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_count", 32'(bus.count), 32'd0);
    checkOutput("arst_empty", 32'(bus.empty), 32'd1);
    checkOutput("arst_data", 32'(bus.data_out), 32'd0);
    checkOutput("arst_sticky", 32'({bus.sticky_ovf, bus.sticky_udf}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    checkOutput("post_rst_udf", 32'(bus.underflow), 32'd1);
    checkOutput("post_rst_valid", 32'(bus.data_valid), 32'd0);
    checkOutput("post_rst_sticky", 32'(bus.sticky_udf), 32'd1);

    $display("[TB] test 6: sticky clear");
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("clr_sticky_udf", 32'(bus.sticky_udf), 32'd0);
    applyStimulus(1'b0, 1'b1, '0, 1'b1);
    checkOutput("clr_vs_set_udf", 32'(bus.sticky_udf), 32'd1);
    checkOutput("clr_vs_set_flag", 32'(bus.underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO that succeeds the team's fixed-depth FIFO. It supports arbitrary (non-power-of-2) depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count, a read-data-valid strobe, and sticky error flags with clear. It sits between a producer and a consumer in the same clock domain and is used as the DUT of the next FIFO verification environment.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 12, number of entries (>=2, any integer, not restricted to a power of 2)
CNT_W, $clog2(FIFO_DEPTH+1), derived localparam; width of count and threshold ports

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  asynchronous reset, active-high
wr_en  input  1  write request
rd_en  input  1  read request
data_in  input  FIFO_WIDTH  write data
af_thresh  input  CNT_W  almost-full threshold; 0 disables almostfull
ae_thresh  input  CNT_W  almost-empty threshold
err_clr  input  1  clears the sticky error flags
data_out  output  FIFO_WIDTH  read data, registered
data_valid  output  1  data_out updated by an accepted read in the previous cycle
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write refused
underflow  output  1  previous-cycle read refused
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almostfull  output  1  (af_thresh != 0) && (count >= af_thresh)
almostempty  output  1  count <= ae_thresh
count  output  CNT_W  current occupancy
sticky_ovf  output  1  latched overflow
sticky_udf  output  1  latched underflow

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, count cleared to 0.
  - data_out, data_valid, wr_ack, overflow, underflow, sticky_ovf, sticky_udf cleared to 0.
  - Therefore full=0, empty=1, almostempty=1, almostfull=0 (unless af_thresh=0, which also gives 0).
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately, with no clock needed.
- Accept rules, evaluated on count at the clock edge:
  - wr_ok = wr_en && (count < FIFO_DEPTH).
  - rd_ok = rd_en && (count > 0).
- Write: on wr_ok, mem[wr_ptr] <= data_in and wr_ptr advances. wr_ptr wraps FIFO_DEPTH-1 -> 0.
- Read: on rd_ok, data_out <= mem[rd_ptr] and rd_ptr advances with the same wrap. Read latency is 1 cycle.
- data_valid is registered as rd_ok. data_out holds its value when no read is accepted.
- count update: next count = count + wr_ok - rd_ok. Both accepted in the same cycle leaves count unchanged.
- Simultaneous wr_en and rd_en:
  - When full: the read is accepted, the write is refused, overflow=1, count becomes FIFO_DEPTH-1.
  - When empty: the write is accepted, the read is refused, underflow=1, data_valid=0, count becomes 1.
  - No same-cycle write-through to the read port.
- Status strobes (registered, 1 cycle after the request):
  - wr_ack = wr_ok.
  - overflow = wr_en && !wr_ok.
  - underflow = rd_en && !rd_ok.
- Sticky flags:
  - sticky_ovf is set by an overflow event and sticky_udf by an underflow event.
  - Both are cleared by err_clr on the next edge.
  - If err_clr and a new event occur in the same cycle, set wins.
- full, empty, almostfull, almostempty: combinational from the count register and the threshold inputs.
  - Thresholds may change at any time; the flags follow in the same cycle.
  - ae_thresh >= FIFO_DEPTH forces almostempty=1.
  - af_thresh > FIFO_DEPTH forces almostfull=0.
- The FIFO never corrupts stored data on refused operations.

Test Plan:
1. Fill/drain with FIFO_DEPTH=12: write 0x0001..0x000C.
   - After the 12th write: count=12, full=1.
   - A 13th write gives wr_ack=0, overflow=1, sticky_ovf=1.
   - 12 reads give data_out 0x0001..0x000C in order with data_valid=1; then empty=1.
2. Wrap-around: write 10, read 10, then write 0xA0..0xA4 (wr_ptr 10, 11, 0, 1, 2).
   - Read 5 gives 0xA0..0xA4 in order; count returns to 0.
3. Simultaneous access at the boundaries:
   - At count=12, wr_en=rd_en=1 gives overflow=1, data_valid=1, count=11.
   - At count=0, wr_en=rd_en=1 gives underflow=1, data_valid=0, wr_ack=1, count=1.
4. Thresholds with af_thresh=10, ae_thresh=2:
   - count=2 gives almostempty=1; count=3 gives 0.
   - count=10 gives almostfull=1; count=9 gives 0.
   - Setting af_thresh=0 at count=12 gives almostfull=0.
5. Asynchronous reset mid-stream: after 5 writes, assert rst between clock edges.
   - count=0, empty=1, data_out=0 and sticky flags=0 immediately.
   - After release, the first read gives underflow=1.
6. Sticky clear: with sticky_udf=1, pulse err_clr and it reads 0 next cycle.
   - Repeat with err_clr and a refused read in the same cycle: sticky_udf stays 1.
